// File: rtl/bram_frame_reader.sv
// Reads one timestamped sample frame from BRAM per frame_done and streams it on AXI-Stream,
// decoding the 4-word header into ts_sec/ts_nsec along the way.
module bram_frame_reader #(
    parameter int FRAME_WORDS  = 40,
    parameter int BASE_ADDR    = 0,
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  frame_done,
    output logic                  bram_clk,
    output logic                  bram_rst,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_en,
    output logic [1:0]            bram_we,
    output logic [15:0]           bram_din,
    input  logic [15:0]           bram_dout,
    output logic [15:0]           m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [31:0]           ts_sec,
    output logic [31:0]           ts_nsec,
    output logic                  ts_valid,
    output logic                  busy,
    output logic [15:0]           overrun_cnt
);
    localparam int IW = $clog2(FRAME_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 2;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                               state, state_nx;
    logic [IW-1:0]                        rd_idx, rd_idx_nx;
    logic [ADDR_WIDTH-1:0]                addr_hold, rd_addr;
    logic [READ_LATENCY-1:0]              pipe_vld;
    logic [READ_LATENCY-1:0][IW-1:0]      pipe_idx;
    logic [FIFO_DEPTH-1:0][16:0]          fifo_mem;
    logic [PW-1:0]                        wr_ptr, rd_ptr;
    logic [CW-1:0]                        fifo_count, inflight;
    logic [15:0]                          sh_sec_hi, sh_sec_lo, sh_ns_hi;
    logic                                 issue, cap, pop, final_hs, accept;
    logic [IW-1:0]                        cap_idx;

    assign bram_clk = aclk;
    assign bram_rst = !aresetn;
    assign bram_we  = 2'b00;
    assign bram_din = 16'h0000;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(pipe_vld[i]);
    end

    // Reserve FIFO space for every read in flight so a capture can never overflow.
    assign issue    = (state == READ) && ((fifo_count + inflight) < CW'(FIFO_DEPTH));
    assign rd_addr  = ADDR_WIDTH'(BASE_ADDR + int'(rd_idx));
    assign bram_en  = issue;
    assign bram_addr = issue ? rd_addr : addr_hold;

    assign cap      = pipe_vld[READ_LATENCY-1];
    assign cap_idx  = pipe_idx[READ_LATENCY-1];
    assign m_axis_tvalid = (fifo_count != '0);
    assign {m_axis_tlast, m_axis_tdata} = fifo_mem[rd_ptr];
    assign pop      = m_axis_tvalid && m_axis_tready;
    assign final_hs = pop && m_axis_tlast;
    assign accept   = frame_done && ((state == IDLE) || final_hs);
    assign busy     = (state != IDLE);

    always_comb begin
        state_nx  = state;
        rd_idx_nx = rd_idx;
        case (state)
            READ: if (issue) begin
                rd_idx_nx = rd_idx + 1'b1;
                if (rd_idx == IW'(FRAME_WORDS - 1)) state_nx = DRAIN;
            end
            DRAIN: if (final_hs) state_nx = IDLE;
            default: ;
        endcase
        // A new frame may start on the very beat that ends the current one.
        if (accept) begin
            state_nx  = READ;
            rd_idx_nx = '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            rd_idx      <= '0;
            addr_hold   <= '0;
            pipe_vld    <= '0;
            pipe_idx    <= '0;
            fifo_mem    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            sh_sec_hi   <= '0;
            sh_sec_lo   <= '0;
            sh_ns_hi    <= '0;
            ts_sec      <= '0;
            ts_nsec     <= '0;
            ts_valid    <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            state  <= state_nx;
            rd_idx <= rd_idx_nx;
            if (issue) addr_hold <= rd_addr;

            pipe_vld[0] <= issue;
            pipe_idx[0] <= rd_idx;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end

            if (cap) begin
                fifo_mem[wr_ptr] <= {cap_idx == IW'(FRAME_WORDS - 1), bram_dout};
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CW'(cap) - CW'(pop);

            // Header decode taps the write side, so it is unaffected by tready.
            ts_valid <= 1'b0;
            if (cap) begin
                if (cap_idx == IW'(0)) sh_sec_hi <= bram_dout;
                if (cap_idx == IW'(1)) sh_sec_lo <= bram_dout;
                if (cap_idx == IW'(2)) sh_ns_hi  <= bram_dout;
                if (cap_idx == IW'(3)) begin
                    ts_sec   <= {sh_sec_hi, sh_sec_lo};
                    ts_nsec  <= {sh_ns_hi, bram_dout};
                    ts_valid <= 1'b1;
                end
            end

            if (frame_done && busy && !final_hs && (overrun_cnt != 16'hFFFF))
                overrun_cnt <= overrun_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_bram_frame_reader.sv
// Randomized bench for bram_frame_reader: BRAM model plus a queue-based frame/overrun reference.
module tb_bram_frame_reader;
    localparam int FW = 40, BASE = 4090, AW = 12, RL = 2, DEPTH = 4;

    logic          aclk = 0, aresetn = 0, frame_done = 0;
    logic          bram_clk, bram_rst, bram_en;
    logic [AW-1:0] bram_addr;
    logic [1:0]    bram_we;
    logic [15:0]   bram_din, bram_dout = '0, d1 = '0;
    logic [15:0]   m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tready = 0, m_axis_tlast;
    logic [31:0]   ts_sec, ts_nsec;
    logic          ts_valid, busy;
    logic [15:0]   overrun_cnt;

    bram_frame_reader #(.FRAME_WORDS(FW), .BASE_ADDR(BASE), .ADDR_WIDTH(AW),
                        .READ_LATENCY(RL), .FIFO_DEPTH(DEPTH)) dut (
        .aclk(aclk), .aresetn(aresetn), .frame_done(frame_done),
        .bram_clk(bram_clk), .bram_rst(bram_rst), .bram_addr(bram_addr), .bram_en(bram_en),
        .bram_we(bram_we), .bram_din(bram_din), .bram_dout(bram_dout),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .ts_sec(ts_sec), .ts_nsec(ts_nsec), .ts_valid(ts_valid),
        .busy(busy), .overrun_cnt(overrun_cnt));

    always #4 aclk = ~aclk;

    int errors = 0, checks = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Two-stage read pipeline: data appears RL=2 cycles after bram_en.
    logic [15:0] mem [0:4095];
    always @(posedge aclk) begin
        if (bram_en) d1 <= mem[bram_addr];
        bram_dout <= d1;
    end

    int cyc = 0;
    initial forever begin @(posedge aclk); cyc++; end

    int mode = 0;  // 0: tready=1, 1: random 30%, 2: tready=0
    initial forever begin
        @(posedge aclk); #1;
        m_axis_tready = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 9) < 3) : 1'b0;
    end

    // Reference: a frame is a list of 40 {tlast,word} beats; busy means beats still owed.
    logic [16:0] exp_q[$];
    int rem = 0, ov_model = 0, addr_k = 0, beat = 0, acc_cyc = 0, first_cyc = 0, last_cyc = 0;
    int ts_pulses = 0;
    bit wait_first = 0, prev_stall = 0, prev_last = 0;
    logic [15:0] prev_data = '0;
    logic [31:0] exp_sec = '0, exp_ns = '0;

    initial forever begin
        @(negedge aclk);
        if (!aresetn) begin
            exp_q.delete(); rem = 0; ov_model = 0; addr_k = 0; beat = 0;
            prev_stall = 0; wait_first = 0;
            continue;
        end
        chk("busy", 64'(busy), 64'(rem != 0));
        chk("overrun", 64'(overrun_cnt), 64'(ov_model));
        chk("bram_const", {bram_we, bram_din, bram_rst}, 64'd0);
        if (bram_en) begin
            chk("bram_addr", 64'(bram_addr), 64'((BASE + addr_k) % 4096));
            addr_k++;
        end
        if (prev_stall) chk("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata},
                            {1'b1, prev_last, prev_data});
        if (m_axis_tvalid && wait_first) begin
            chk("first_latency", 64'(cyc - acc_cyc >= RL + 1), 64'd1);
            wait_first = 0;
        end
        if (ts_valid) begin
            chk("timestamp", {ts_sec, ts_nsec}, {exp_sec, exp_ns});
            ts_pulses++;
        end
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) chk("extra_beat", 64'd1, 64'd0);
            else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                chk("beat", {m_axis_tlast, m_axis_tdata}, 64'(e));
                if (beat == 0) first_cyc = cyc;
                beat++;
                if (e[16]) begin last_cyc = cyc; beat = 0; end
                rem--;
            end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_last  = m_axis_tlast;
        prev_data  = m_axis_tdata;
        if (frame_done) begin
            if (rem == 0) begin
                for (int k = 0; k < FW; k++)
                    exp_q.push_back({k == FW - 1, mem[(BASE + k) % 4096]});
                exp_sec = {mem[(BASE + 0) % 4096], mem[(BASE + 1) % 4096]};
                exp_ns  = {mem[(BASE + 2) % 4096], mem[(BASE + 3) % 4096]};
                rem = FW; addr_k = 0; acc_cyc = cyc; wait_first = 1;
            end else if (ov_model < 65535) ov_model++;
        end
    end

    task automatic load_frame(input bit fixed);
        for (int k = 0; k < FW; k++)
            mem[(BASE + k) % 4096] = fixed ? 16'(k + 1) : 16'($urandom);
    endtask

    task automatic pulse_fd();
        @(posedge aclk); #1 frame_done = 1;
        @(posedge aclk); #1 frame_done = 0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge aclk); #2;
            if (!busy && exp_q.size() == 0 && !frame_done) ok = 1;
        end
        chk("idle_timeout", 64'(ok), 64'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {busy, m_axis_tvalid, m_axis_tlast, ts_valid, bram_en,
                  m_axis_tdata, overrun_cnt, bram_addr}, 64'd0);
        chk({tag, "_ts"}, {ts_sec, ts_nsec}, 64'd0);
        chk({tag, "_rst"}, 64'(bram_rst), 64'd1);
    endtask

    initial begin
        bit found, fd_prev;
        load_frame(1);
        repeat (3) @(posedge aclk);
        #1 chk_zero("reset");
        aresetn = 1;

        // T1: fixed frame, full throughput
        mode = 0; ts_pulses = 0;
        pulse_fd(); wait_idle();
        chk("t1_ts", {ts_sec, ts_nsec}, 64'h0001_0002_0003_0004);
        chk("t1_ts_pulses", 64'(ts_pulses), 64'd1);
        chk("t1_throughput", 64'(last_cyc - first_cyc), 64'(FW - 1));

        // T2: same frame under random backpressure
        mode = 1;
        pulse_fd(); wait_idle();

        // T3: frame_done while stalled mid-frame
        load_frame(0); mode = 2;
        pulse_fd();
        repeat (10) @(posedge aclk);
        pulse_fd();
        repeat (3) @(posedge aclk);
        #2 chk("t3_overrun", 64'(overrun_cnt), 64'd1);
        chk("t3_busy", 64'(busy), 64'd1);
        mode = 1; wait_idle();
        pulse_fd(); wait_idle();

        // T4: frame_done on the final tlast handshake
        mode = 0; found = 0;
        pulse_fd();
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge aclk); #2;
            if (m_axis_tvalid && m_axis_tlast && m_axis_tready) begin
                frame_done = 1; found = 1;
                @(posedge aclk); #1 frame_done = 0;
            end
        end
        chk("t4_coincident", 64'(found), 64'd1);
        #1 chk("t4_busy_kept", 64'(busy), 64'd1);
        wait_idle();
        chk("t4_overrun", 64'(overrun_cnt), 64'd1);

        // T5: reset in the middle of a frame
        load_frame(0); mode = 0; found = 0;
        pulse_fd();
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge aclk); #2;
            if (beat >= 17) found = 1;
        end
        chk("t5_reached_17", 64'(found), 64'd1);
        aresetn = 0;
        #1 chk_zero("t5_reset");
        repeat (3) @(posedge aclk);
        #1 aresetn = 1;
        ts_pulses = 0;
        pulse_fd(); wait_idle();
        chk("t5_ts_pulses", 64'(ts_pulses), 64'd1);

        // Random frames with random extra frame_done pulses
        for (int f = 0; f < 4; f++) begin
            load_frame(0); mode = 1; fd_prev = 0;
            pulse_fd();
            for (int i = 0; i < 250; i++) begin
                @(posedge aclk); #1;
                frame_done = !fd_prev && ($urandom_range(0, 39) == 0);
                fd_prev = frame_done;
            end
            @(posedge aclk); #1 frame_done = 0;
            wait_idle();
        end
        chk("final_overrun", 64'(overrun_cnt), 64'(ov_model));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
